// File: rtl/row_seq_pkg.sv
// ----------------------------------------------------------------------------
// row_seq_pkg
// Shared types for the word-line row sequencer.
//   op_mode_e : operation codes carried on op_mode
//   state_e   : sequencer FSM states
//   is_mac()  : true for the two multi-row MAC modes
// The PRE state is only reachable when ROW_SEQ_PRECHARGE_EN is defined.
// ----------------------------------------------------------------------------
package row_seq_pkg;

   typedef enum logic [1:0] {
      WRITE   = 2'b00,
      MAC_WL  = 2'b01,
      MAC_WLB = 2'b10,
      CAM     = 2'b11
   } op_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PRE   = 2'b01,
      PULSE = 2'b10
   } state_e;

   function automatic logic is_mac(input op_mode_e i_mode);
      return (i_mode == MAC_WL) || (i_mode == MAC_WLB);
   endfunction

endpackage

// File: rtl/row_onehot_dec.sv
// ----------------------------------------------------------------------------
// row_onehot_dec
// Combinational binary-to-one-hot row decoder.
//   i_row    [ADDR_W-1:0]   row number
//   o_onehot [2**ADDR_W-1:0] single bit set at position i_row
// ----------------------------------------------------------------------------
module row_onehot_dec #(
   parameter  int ADDR_W = 4,
   localparam int ROWS   = 2 ** ADDR_W
) (
   input  logic [ADDR_W-1:0] i_row,
   output logic [ROWS-1:0]   o_onehot
);

   always_comb begin
      o_onehot        = '0;
      o_onehot[i_row] = 1'b1;
   end

endmodule

// File: rtl/row_sequencer.sv
// ----------------------------------------------------------------------------
// row_sequencer
// Word-line pulse sequencer for a compute-in-memory array. Accepts one
// operation at a time and drives registered WL/WLB patterns for PULSE_CYC
// cycles per row; MAC modes walk burst_len+1 consecutive rows (wrapping).
//
// Build option: ROW_SEQ_PRECHARGE_EN -- when defined, every pulse is preceded
// by PRE_CYC precharge cycles with WL=WLB=0; when undefined, pulses run
// back-to-back and the row switches on a single edge.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   cs         in   chip select; low aborts any operation
//   op_valid   in   operation request
//   op_ready   out  sequencer idle and selected
//   op_mode    in   [1:0] WRITE / MAC_WL / MAC_WLB / CAM
//   addr       in   [ADDR_W-1:0] start row
//   burst_len  in   [ADDR_W-1:0] MAC rows minus one
//   data       in   [ROWS-1:0] CAM search key
//   WL, WLB    out  [ROWS-1:0] registered word lines
//   row_idx    out  [ADDR_W-1:0] row currently pulsed
//   done       out  one-cycle completion pulse
// ----------------------------------------------------------------------------
module row_sequencer
   import row_seq_pkg::*;
#(
   parameter  int ROWS      = 16,
   parameter  int PULSE_CYC = 2,
   parameter  int PRE_CYC   = 1,
   localparam int ADDR_W    = $clog2(ROWS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [1:0]        op_mode,
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] burst_len,
   input  logic [ROWS-1:0]   data,
   output logic [ROWS-1:0]   WL,
   output logic [ROWS-1:0]   WLB,
   output logic [ADDR_W-1:0] row_idx,
   output logic              done
);

   // One down-counter serves both the precharge gap and the pulse width.
   localparam int CNT_MAX = (PULSE_CYC > PRE_CYC) ? PULSE_CYC : PRE_CYC;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
`ifdef ROW_SEQ_PRECHARGE_EN
   localparam logic [CNT_W-1:0] PRE_LOAD   = CNT_W'(PRE_CYC - 1);
`endif

   state_e              r_state,  w_state_nxt;
   logic [CNT_W-1:0]    r_cnt,    w_cnt_nxt;
   logic [ADDR_W-1:0]   r_left,   w_left_nxt;
   op_mode_e            r_mode,   w_mode_nxt;
   logic [ROWS-1:0]     r_data,   w_data_nxt;
   logic [ADDR_W-1:0]   r_row,    w_row_nxt;
   logic                r_done,   w_done_nxt;
   logic [ROWS-1:0]     r_wl,     w_wl_nxt;
   logic [ROWS-1:0]     r_wlb,    w_wlb_nxt;
   logic [ROWS-1:0]     w_onehot;
   logic                w_accept;

   assign op_ready = (r_state == IDLE) & cs & ~rst;
   assign w_accept = op_valid & op_ready;

   // Next-state / next-field logic. Fields are taken straight from the inputs
   // on the accept edge so the first pulse can start on that same edge.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a variable unassigned, which would otherwise infer a latch.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_left_nxt  = r_left;
      w_mode_nxt  = r_mode;
      w_data_nxt  = r_data;
      w_row_nxt   = r_row;
      w_done_nxt  = 1'b0;

      if (!cs) begin
         // Abort: drop the rest of any burst, no completion pulse.
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
         w_left_nxt  = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  w_mode_nxt = op_mode_e'(op_mode);
                  w_data_nxt = data;
                  w_row_nxt  = addr;
                  w_left_nxt = is_mac(op_mode_e'(op_mode)) ? burst_len : '0;
`ifdef ROW_SEQ_PRECHARGE_EN
                  w_state_nxt = PRE;
                  w_cnt_nxt   = PRE_LOAD;
`else
                  w_state_nxt = PULSE;
                  w_cnt_nxt   = PULSE_LOAD;
`endif
               end
            end
`ifdef ROW_SEQ_PRECHARGE_EN
            PRE: begin
               if (r_cnt == '0) begin
                  w_state_nxt = PULSE;
                  w_cnt_nxt   = PULSE_LOAD;
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
`endif
            PULSE: begin
               if (r_cnt != '0) begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end else if (r_left == '0) begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  // ROWS is a power of two, so the increment wraps naturally.
                  w_left_nxt = r_left - 1'b1;
                  w_row_nxt  = r_row + 1'b1;
`ifdef ROW_SEQ_PRECHARGE_EN
                  w_state_nxt = PRE;
                  w_cnt_nxt   = PRE_LOAD;
`else
                  w_cnt_nxt   = PULSE_LOAD;
`endif
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   row_onehot_dec #(
      .ADDR_W (ADDR_W)
   ) u_dec (
      .i_row    (w_row_nxt),
      .o_onehot (w_onehot)
   );

   // Word-line pattern for the coming cycle; nonzero only while pulsing.
   always_comb begin
      w_wl_nxt  = '0;
      w_wlb_nxt = '0;
      if (w_state_nxt == PULSE) begin
         case (w_mode_nxt)
            WRITE: begin
               w_wl_nxt  = w_onehot;
               w_wlb_nxt = w_onehot;
            end
            MAC_WL:  w_wl_nxt  = w_onehot;
            MAC_WLB: w_wlb_nxt = w_onehot;
            CAM: begin
               w_wl_nxt  = w_data_nxt;
               w_wlb_nxt = ~w_data_nxt;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_left  <= '0;
         r_mode  <= WRITE;
         r_data  <= '0;
         r_row   <= '0;
         r_done  <= 1'b0;
         r_wl    <= '0;
         r_wlb   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_left  <= w_left_nxt;
         r_mode  <= w_mode_nxt;
         r_data  <= w_data_nxt;
         r_row   <= w_row_nxt;
         r_done  <= w_done_nxt;
         r_wl    <= w_wl_nxt;
         r_wlb   <= w_wlb_nxt;
      end
   end

   assign WL      = r_wl;
   assign WLB     = r_wlb;
   assign row_idx = r_row;
   assign done    = r_done;

endmodule

// File: tb/tb_row_sequencer.sv
// ----------------------------------------------------------------------------
// tb_row_sequencer
// Directed bench for row_sequencer with ROWS=16, PULSE_CYC=2, PRE_CYC=1.
// Expectations adapt to ROW_SEQ_PRECHARGE_EN (one zero gap cycle per pulse).
// ----------------------------------------------------------------------------
module tb_row_sequencer;

   logic        clk;
   logic        rst;
   logic        cs;
   logic        op_valid;
   logic        op_ready;
   logic [1:0]  op_mode;
   logic [3:0]  addr;
   logic [3:0]  burst_len;
   logic [15:0] data;
   logic [15:0] WL;
   logic [15:0] WLB;
   logic [3:0]  row_idx;
   logic        done;

   int total = 0;
   int bad   = 0;

   row_sequencer #(
      .ROWS      (16),
      .PULSE_CYC (2),
      .PRE_CYC   (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cs        (cs),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_mode   (op_mode),
      .addr      (addr),
      .burst_len (burst_len),
      .data      (data),
      .WL        (WL),
      .WLB       (WLB),
      .row_idx   (row_idx),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request in the current cycle; returns one cycle after accept.
   task automatic issue(input logic [1:0] m, input logic [3:0] a, input logic [3:0] bl,
                        input logic [15:0] k, input bit hold);
      chk("issue_ready", 32'(op_ready), 32'd1);
      op_mode   = m;
      addr      = a;
      burst_len = bl;
      data      = k;
      op_valid  = 1'b1;
      step();
      if (!hold) op_valid = 1'b0;
   endtask

   // One row: optional precharge gap, then two pulse cycles.
   task automatic pulse_chk(input string tag, input logic [15:0] ewl, input logic [15:0] ewlb,
                            input logic [3:0] erow);
`ifdef ROW_SEQ_PRECHARGE_EN
      chk({tag, "_pre_wl"},  32'(WL),  32'd0);
      chk({tag, "_pre_wlb"}, 32'(WLB), 32'd0);
      chk({tag, "_pre_row"}, 32'(row_idx), 32'(erow));
      step();
`endif
      for (int c = 0; c < 2; c++) begin
         chk({tag, "_wl"},    32'(WL),       32'(ewl));
         chk({tag, "_wlb"},   32'(WLB),      32'(ewlb));
         chk({tag, "_done"},  32'(done),     32'd0);
         chk({tag, "_row"},   32'(row_idx),  32'(erow));
         chk({tag, "_ready"}, 32'(op_ready), 32'd0);
         step();
      end
   endtask

   task automatic done_chk(input string tag);
      chk({tag, "_done"},  32'(done),     32'd1);
      chk({tag, "_wl0"},   32'(WL),       32'd0);
      chk({tag, "_wlb0"},  32'(WLB),      32'd0);
      chk({tag, "_ready"}, 32'(op_ready), 32'd1);
      step();
      chk({tag, "_done_clr"}, 32'(done), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      cs        = 1'b1;
      op_valid  = 1'b0;
      op_mode   = 2'b00;
      addr      = 4'd0;
      burst_len = 4'd0;
      data      = 16'h0000;

      // Reset state
      step();
      step();
      chk("rst_wl",    32'(WL),       32'd0);
      chk("rst_wlb",   32'(WLB),      32'd0);
      chk("rst_done",  32'(done),     32'd0);
      chk("rst_row",   32'(row_idx),  32'd0);
      chk("rst_ready", 32'(op_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("rel_ready", 32'(op_ready), 32'd1);

      // WRITE row 5
      issue(2'b00, 4'd5, 4'd0, 16'h0000, 1'b0);
      pulse_chk("wr5", 16'h0020, 16'h0020, 4'd5);
      done_chk("wr5");

      // MAC_WLB from row 14, four rows, wraps 15 -> 0
      issue(2'b10, 4'd14, 4'd3, 16'h0000, 1'b0);
      pulse_chk("wlb_r14", 16'h0000, 16'h4000, 4'd14);
      pulse_chk("wlb_r15", 16'h0000, 16'h8000, 4'd15);
      pulse_chk("wlb_r0",  16'h0000, 16'h0001, 4'd0);
      pulse_chk("wlb_r1",  16'h0000, 16'h0002, 4'd1);
      done_chk("wlb");

      // CAM: key on WL, inverse on WLB; burst_len ignored
      issue(2'b11, 4'd0, 4'd5, 16'hA5C3, 1'b0);
      pulse_chk("cam", 16'hA5C3, 16'h5A3C, 4'd0);
      done_chk("cam");

      // MAC_WL, eight rows from 2; cs dropped in the third pulse
      issue(2'b01, 4'd2, 4'd7, 16'h0000, 1'b0);
      pulse_chk("csd_r2", 16'h0004, 16'h0000, 4'd2);
      pulse_chk("csd_r3", 16'h0008, 16'h0000, 4'd3);
`ifdef ROW_SEQ_PRECHARGE_EN
      chk("csd_pre_wl", 32'(WL), 32'd0);
      step();
`endif
      chk("csd_r4_wl", 32'(WL), 32'h0010);
      cs = 1'b0;
      #1;
      chk("csd_ready_low", 32'(op_ready), 32'd0);
      step();
      chk("csd_wl0",    32'(WL),       32'd0);
      chk("csd_wlb0",   32'(WLB),      32'd0);
      chk("csd_nodone", 32'(done),     32'd0);
      chk("csd_ready0", 32'(op_ready), 32'd0);
      step();
      chk("csd_nodone2", 32'(done), 32'd0);
      chk("csd_wl0_2",   32'(WL),   32'd0);
      cs = 1'b1;
      #1;
      chk("csd_ready_back", 32'(op_ready), 32'd1);

      // Reset in the middle of a MAC_WL burst
      issue(2'b01, 4'd0, 4'd3, 16'h0000, 1'b0);
      pulse_chk("rmid_r0", 16'h0001, 16'h0000, 4'd0);
`ifdef ROW_SEQ_PRECHARGE_EN
      step();
`endif
      chk("rmid_r1_wl", 32'(WL), 32'h0002);
      rst = 1'b1;
      #1;
      chk("rmid_ready_rst", 32'(op_ready), 32'd0);
      step();
      chk("rmid_wl0",   32'(WL),       32'd0);
      chk("rmid_wlb0",  32'(WLB),      32'd0);
      chk("rmid_done0", 32'(done),     32'd0);
      chk("rmid_row0",  32'(row_idx),  32'd0);
      chk("rmid_ready", 32'(op_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("rmid_ready_rel", 32'(op_ready), 32'd1);
      issue(2'b00, 4'd9, 4'd0, 16'h0000, 1'b0);
      pulse_chk("rmid_wr9", 16'h0200, 16'h0200, 4'd9);
      done_chk("rmid_wr9");

      // op_valid held through a busy period: second op taken in done cycle
      issue(2'b01, 4'd7, 4'd1, 16'h0000, 1'b1);
      op_mode   = 2'b10;
      addr      = 4'd12;
      burst_len = 4'd0;
      pulse_chk("hold_a7", 16'h0080, 16'h0000, 4'd7);
      pulse_chk("hold_a8", 16'h0100, 16'h0000, 4'd8);
      chk("hold_a_done",  32'(done),     32'd1);
      chk("hold_a_wl0",   32'(WL),       32'd0);
      chk("hold_a_ready", 32'(op_ready), 32'd1);
      step();
      op_valid = 1'b0;
      pulse_chk("hold_b12", 16'h0000, 16'h1000, 4'd12);
      done_chk("hold_b");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
